// File: rtl/chipscope_probe_ctrl.sv
// chipscope_probe_ctrl: selects one 16-bit probe group onto the ILA trigger bus,
// qualifies a one-cycle fire strobe on the chosen bit, and sequences
// arm -> fire -> holdoff/done from a VIO control word that is asynchronous to CLK.
module chipscope_probe_ctrl #(
    parameter int NUM_GRP     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [16*NUM_GRP-1:0]  I_PROBE_GRP,
    input  logic [15:0]            I_VIO_CTRL,
    output logic [16:0]            O_TRIG,
    output logic [1:0]             O_STATE,
    output logic [7:0]             O_FIRE_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [5:0] holdoff;
        logic       mode;
        logic       pol;
        logic [3:0] bit_idx;
        logic       arm;
        logic       clear;
        logic [1:0] grp_sel;
    } cfg_t;

    localparam logic [2:0] FILL_LAST = 3'(SYNC_STAGES + 1);

    logic [15:0] sync_q [SYNC_STAGES];
    logic [15:0] synced;
    logic [15:0] prev_q;
    logic        stable;
    logic [2:0]  fill_cnt;
    logic        fill_done;
    logic        primed_q;
    cfg_t        cfg_q;

    logic [15:0] sel_data;
    logic [15:0] data_q;
    logic        fire_q;
    logic        nxt_bit;
    logic        cur_bit;
    logic        edge_det;
    logic [5:0]  sel_q;
    logic        sel_changed;
    logic        arm_q;
    logic        arm_rise;

    state_t      state_q, state_d;
    logic [5:0]  hold_q, hold_d;
    logic        fire;
    logic [7:0]  cnt_q;

    assign synced    = sync_q[SYNC_STAGES-1];
    assign stable    = (synced == prev_q);
    assign fill_done = (fill_cnt == FILL_LAST);

    // Synchronizer chain for the asynchronous VIO word.
    // NOTE: every stage of the array is reset explicitly; an unreset stage would
    // let an arbitrary power-up word reach the skew filter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= I_VIO_CTRL;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Skew filter: accept the synced word only once it matched on two cycles.
    // Arming is only allowed after a genuine post-reset word with arm low was seen.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prev_q   <= '0;
            cfg_q    <= '0;
            fill_cnt <= '0;
            primed_q <= 1'b0;
        end else begin
            prev_q <= synced;
            if (!fill_done) fill_cnt <= fill_cnt + 3'd1;
            if (stable) cfg_q <= cfg_t'(synced);
            if (fill_done && stable && !synced[3]) primed_q <= 1'b1;
        end
    end

    // Probe group mux; selects beyond NUM_GRP read as zero.
    // NOTE: sel_data is defaulted before the loop so no latch is inferred.
    always_comb begin
        sel_data = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            if (cfg_q.grp_sel == 2'(g)) sel_data = I_PROBE_GRP[16*g +: 16];
        end
    end

    assign nxt_bit     = sel_data[cfg_q.bit_idx];
    assign cur_bit     = data_q[cfg_q.bit_idx];
    assign edge_det    = cfg_q.pol ? (cur_bit & ~nxt_bit) : (~cur_bit & nxt_bit);
    assign sel_changed = ({cfg_q.grp_sel, cfg_q.bit_idx} != sel_q);
    assign arm_rise    = cfg_q.arm & ~arm_q & primed_q;

    // Next-state and fire qualification; clear and disarm take priority.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        fire    = 1'b0;
        if (cfg_q.clear || !cfg_q.arm) begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end else if (sel_changed && (state_q == ST_ARMED || state_q == ST_HOLDOFF)) begin
            // Edge history belongs to the old selection, so the capture is dropped.
            state_d = ST_IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_rise) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (edge_det) begin
                        fire = 1'b1;
                        if (!cfg_q.mode) begin
                            state_d = ST_DONE;
                        end else if (cfg_q.holdoff == 6'd0) begin
                            state_d = ST_ARMED;
                        end else begin
                            state_d = ST_HOLDOFF;
                            hold_d  = 6'd1;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_q >= cfg_q.holdoff) begin
                        state_d = ST_ARMED;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, trigger bus, selection history and saturating fire counter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            data_q  <= '0;
            fire_q  <= 1'b0;
            sel_q   <= '0;
            arm_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= sel_data;
            fire_q  <= fire;
            sel_q   <= {cfg_q.grp_sel, cfg_q.bit_idx};
            arm_q   <= cfg_q.arm;
            if (cfg_q.clear) cnt_q <= '0;
            else if (fire && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        end
    end

    assign O_TRIG     = {fire_q, data_q};
    assign O_STATE    = state_q;
    assign O_FIRE_CNT = cnt_q;

endmodule
